// File: rtl/decoder_xpt_sequencer.sv
// decoder_xpt_sequencer: opcode latch, XPT phase counter and masked OR-merge of CH sub-decoder channels.
// Optional XPT_OVERFLOW_TRAP_EN: phase wrap without end-of-instruction forces a return to fetch and sets a sticky trap.
module decoder_xpt_sequencer #(
   parameter int XPT_W   = 4,
   parameter int OP_W    = 8,
   parameter int CH      = 2,
   parameter int CW      = 32,
   parameter int SEL_LSB = 4,
   parameter int EOI_BIT = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [OP_W-1:0]    op_in,
   input  logic               op_valid,
   input  logic               stall,
   input  logic [CH*CW-1:0]   ch_ctrl,
   output logic [CH-1:0]      ch_en,
   output logic [XPT_W-1:0]   xpt,
   output logic [XPT_W-1:0]   not_xpt,
   output logic [OP_W-1:0]    itable,
   output logic [OP_W-1:0]    not_itable,
   output logic [CW-1:0]      ctrl_out,
   output logic               cm1,
   output logic               eoi,
   output logic               trap
);
   localparam int SEL_W = $clog2(CH);
   typedef enum logic {FETCH, EXEC} state_t;
   state_t state, state_nx;
   logic [XPT_W-1:0] xpt_nx;
   logic [OP_W-1:0] itable_nx;
   logic [SEL_W-1:0] sel;
   logic [CW-1:0] merged;
   logic active, end_hit, eoi_nx, trap_nx;
   assign sel = itable[SEL_LSB +: SEL_W];
   assign ch_en = (state == EXEC) ? CH'(1) << sel : '0;
   always_comb begin
      merged = '0;
      for (int i = 0; i < CH; i++) merged = merged | (ch_ctrl[i*CW +: CW] & {CW{ch_en[i]}});
   end
   assign active = (state == EXEC) && !stall;
   assign ctrl_out = active ? merged : '0;
`ifdef XPT_OVERFLOW_TRAP_EN
   logic wrap;
   assign wrap = active && !ctrl_out[EOI_BIT] && (xpt == '1);
   assign end_hit = active && (ctrl_out[EOI_BIT] || wrap);
   assign trap_nx = trap | wrap;
`else
   assign end_hit = active && ctrl_out[EOI_BIT];
   assign trap_nx = 1'b0;
`endif
   always_comb begin
      state_nx = state;
      xpt_nx = xpt;
      itable_nx = itable;
      eoi_nx = 1'b0;
      if (state == FETCH) begin
         if (op_valid && !stall) begin
            state_nx = EXEC;
            itable_nx = op_in;
            xpt_nx = '0;
         end
      end else if (end_hit) begin
         state_nx = FETCH;
         xpt_nx = '0;
         itable_nx = '0;
         eoi_nx = 1'b1;
      end else if (active) begin
         xpt_nx = xpt + 1'b1;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= FETCH;
         xpt <= '0;
         itable <= '0;
         eoi <= 1'b0;
         trap <= 1'b0;
      end else begin
         state <= state_nx;
         xpt <= xpt_nx;
         itable <= itable_nx;
         eoi <= eoi_nx;
         trap <= trap_nx;
      end
   end
   assign cm1 = (state == FETCH);
   assign not_xpt = ~xpt;
   assign not_itable = ~itable;
endmodule

// File: tb/tb_decoder_xpt_sequencer.sv
// tb_decoder_xpt_sequencer: directed checks of fetch, channel select, masking, stall, reset and phase overflow.
module tb_decoder_xpt_sequencer;
   logic clk = 1'b0;
   logic reset, op_valid, stall;
   logic [7:0] op_in;
   logic [63:0] ch_ctrl;
   logic [1:0] ch_en;
   logic [3:0] xpt, not_xpt;
   logic [7:0] itable, not_itable;
   logic [31:0] ctrl_out;
   logic cm1, eoi, trap;
   int checks = 0;
   int errors = 0;

   decoder_xpt_sequencer dut (
      .clk(clk), .reset(reset), .op_in(op_in), .op_valid(op_valid), .stall(stall),
      .ch_ctrl(ch_ctrl), .ch_en(ch_en), .xpt(xpt), .not_xpt(not_xpt), .itable(itable),
      .not_itable(not_itable), .ctrl_out(ctrl_out), .cm1(cm1), .eoi(eoi), .trap(trap)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [7:0] op);
      op_in = op;
      op_valid = 1'b1;
      tick();
      op_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; op_valid = 1'b0; stall = 1'b0; op_in = 8'h00; ch_ctrl = '0;
      tick(); tick();
      reset = 1'b0;
      checks++; if (cm1 !== 1'b1) begin errors++; $display("FAIL reset_cm1 got %b want 1", cm1); end
      checks++; if (xpt !== 4'h0) begin errors++; $display("FAIL reset_xpt got %h want 0", xpt); end
      checks++; if (itable !== 8'h00) begin errors++; $display("FAIL reset_itable got %h want 00", itable); end
      checks++; if (ctrl_out !== 32'h0) begin errors++; $display("FAIL reset_ctrl got %h want 0", ctrl_out); end
      checks++; if (ch_en !== 2'b00) begin errors++; $display("FAIL reset_ch_en got %b want 00", ch_en); end
      checks++; if (eoi !== 1'b0) begin errors++; $display("FAIL reset_eoi got %b want 0", eoi); end
      checks++; if (trap !== 1'b0) begin errors++; $display("FAIL reset_trap got %b want 0", trap); end
      checks++; if (not_xpt !== 4'hF) begin errors++; $display("FAIL reset_not_xpt got %h want F", not_xpt); end
      checks++; if (not_itable !== 8'hFF) begin errors++; $display("FAIL reset_not_itable got %h want FF", not_itable); end
      for (int c = 0; c < 5; c++) begin
         tick();
         checks++; if (cm1 !== 1'b1 || xpt !== 4'h0) begin errors++; $display("FAIL idle_hold got cm1=%b xpt=%h want cm1=1 xpt=0", cm1, xpt); end
      end
   endtask

   task automatic test_fetch_select();
      ch_ctrl = {32'h0000_0002, 32'h0000_0080};
      load(8'h19);
      checks++; if (itable !== 8'h19) begin errors++; $display("FAIL fetch_itable got %h want 19", itable); end
      checks++; if (not_itable !== 8'hE6) begin errors++; $display("FAIL fetch_not_itable got %h want E6", not_itable); end
      checks++; if (ch_en !== 2'b10) begin errors++; $display("FAIL fetch_ch_en got %b want 10", ch_en); end
      checks++; if (cm1 !== 1'b0) begin errors++; $display("FAIL fetch_cm1 got %b want 0", cm1); end
      for (int p = 0; p < 4; p++) begin
         ch_ctrl = {(p == 3) ? 32'h0000_0003 : 32'h0000_0002, 32'h0000_0080};
         #1;
         checks++; if (xpt !== p[3:0]) begin errors++; $display("FAIL fetch_xpt got %h want %h", xpt, p[3:0]); end
         checks++; if (ctrl_out !== ((p == 3) ? 32'h3 : 32'h2)) begin errors++; $display("FAIL fetch_ctrl p=%0d got %h want %h", p, ctrl_out, (p == 3) ? 32'h3 : 32'h2); end
         checks++; if (eoi !== 1'b0) begin errors++; $display("FAIL fetch_eoi_early got %b want 0", eoi); end
         tick();
      end
      checks++; if (eoi !== 1'b1) begin errors++; $display("FAIL fetch_eoi got %b want 1", eoi); end
      checks++; if (cm1 !== 1'b1 || xpt !== 4'h0 || itable !== 8'h00) begin errors++; $display("FAIL fetch_return got cm1=%b xpt=%h itable=%h want 1 0 00", cm1, xpt, itable); end
      checks++; if (ch_en !== 2'b00 || ctrl_out !== 32'h0) begin errors++; $display("FAIL fetch_gate got ch_en=%b ctrl=%h want 00 0", ch_en, ctrl_out); end
      tick();
      checks++; if (eoi !== 1'b0) begin errors++; $display("FAIL fetch_eoi_pulse got %b want 0", eoi); end
   endtask

   task automatic test_masking();
      load(8'h09);
      checks++; if (ch_en !== 2'b01) begin errors++; $display("FAIL mask_ch_en got %b want 01", ch_en); end
      ch_ctrl = {32'hFFFF_FFFF, 32'h0000_0004};
      #1;
      checks++; if (ctrl_out !== 32'h4) begin errors++; $display("FAIL mask_ctrl0 got %h want 4", ctrl_out); end
      tick();
      checks++; if (xpt !== 4'h1) begin errors++; $display("FAIL mask_xpt got %h want 1", xpt); end
      ch_ctrl = {32'hFFFF_FFFF, 32'h0000_0001};
      #1;
      checks++; if (ctrl_out !== 32'h1) begin errors++; $display("FAIL mask_ctrl1 got %h want 1", ctrl_out); end
      tick();
      checks++; if (eoi !== 1'b1 || cm1 !== 1'b1) begin errors++; $display("FAIL mask_eoi got eoi=%b cm1=%b want 1 1", eoi, cm1); end
   endtask

   task automatic test_back_to_back_stall();
      ch_ctrl = {32'h0000_0002, 32'h0};
      load(8'h19);
      checks++; if (cm1 !== 1'b0 || itable !== 8'h19) begin errors++; $display("FAIL b2b_accept got cm1=%b itable=%h want 0 19", cm1, itable); end
      tick(); tick();
      checks++; if (xpt !== 4'h2) begin errors++; $display("FAIL stall_xpt_start got %h want 2", xpt); end
      ch_ctrl = {32'h0000_0003, 32'h0};
      stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++; if (ctrl_out !== 32'h0) begin errors++; $display("FAIL stall_ctrl got %h want 0", ctrl_out); end
         tick();
         checks++; if (xpt !== 4'h2 || eoi !== 1'b0 || cm1 !== 1'b0) begin errors++; $display("FAIL stall_hold got xpt=%h eoi=%b cm1=%b want 2 0 0", xpt, eoi, cm1); end
      end
      stall = 1'b0;
      #1;
      checks++; if (ctrl_out !== 32'h3) begin errors++; $display("FAIL stall_release_ctrl got %h want 3", ctrl_out); end
      tick();
      checks++; if (eoi !== 1'b1 || cm1 !== 1'b1 || xpt !== 4'h0) begin errors++; $display("FAIL stall_eoi got eoi=%b cm1=%b xpt=%h want 1 1 0", eoi, cm1, xpt); end
      op_in = 8'h09; op_valid = 1'b1; stall = 1'b1;
      tick();
      checks++; if (cm1 !== 1'b1) begin errors++; $display("FAIL stall_fetch got cm1=%b want 1", cm1); end
      stall = 1'b0;
      tick();
      op_valid = 1'b0;
      checks++; if (cm1 !== 1'b0 || itable !== 8'h09) begin errors++; $display("FAIL stall_fetch_accept got cm1=%b itable=%h want 0 09", cm1, itable); end
      ch_ctrl = {32'h0, 32'h0000_0001};
      tick();
   endtask

   task automatic test_reset_mid();
      ch_ctrl = {32'h0000_0002, 32'h0};
      load(8'h19);
      for (int c = 0; c < 5; c++) tick();
      checks++; if (xpt !== 4'h5) begin errors++; $display("FAIL rmid_xpt_start got %h want 5", xpt); end
      ch_ctrl = {32'h0000_0003, 32'h0};
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (cm1 !== 1'b1 || xpt !== 4'h0 || itable !== 8'h00 || eoi !== 1'b0) begin errors++; $display("FAIL rmid got cm1=%b xpt=%h itable=%h eoi=%b want 1 0 00 0", cm1, xpt, itable, eoi); end
      checks++; if (ctrl_out !== 32'h0 || ch_en !== 2'b00) begin errors++; $display("FAIL rmid_gate got ctrl=%h ch_en=%b want 0 00", ctrl_out, ch_en); end
   endtask

   task automatic test_overflow();
      ch_ctrl = {32'h0000_0002, 32'h0};
      load(8'h19);
      for (int p = 0; p < 16; p++) begin
         checks++; if (xpt !== p[3:0]) begin errors++; $display("FAIL ovf_xpt got %h want %h", xpt, p[3:0]); end
         tick();
      end
`ifdef XPT_OVERFLOW_TRAP_EN
      checks++; if (trap !== 1'b1 || eoi !== 1'b1 || cm1 !== 1'b1 || xpt !== 4'h0) begin errors++; $display("FAIL ovf_trap got trap=%b eoi=%b cm1=%b xpt=%h want 1 1 1 0", trap, eoi, cm1, xpt); end
      tick();
      checks++; if (trap !== 1'b1 || eoi !== 1'b0) begin errors++; $display("FAIL ovf_sticky got trap=%b eoi=%b want 1 0", trap, eoi); end
`else
      checks++; if (xpt !== 4'h0 || cm1 !== 1'b0 || trap !== 1'b0 || eoi !== 1'b0) begin errors++; $display("FAIL ovf_wrap got xpt=%h cm1=%b trap=%b eoi=%b want 0 0 0 0", xpt, cm1, trap, eoi); end
      tick();
      checks++; if (xpt !== 4'h1 || cm1 !== 1'b0) begin errors++; $display("FAIL ovf_continue got xpt=%h cm1=%b want 1 0", xpt, cm1); end
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_fetch_select();
      test_masking();
      test_back_to_back_stall();
      test_reset_mid();
      test_overflow();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
